// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the TX/RX state encodings.
package mmio_uart_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_RXDATA = 4'hC;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_BUSY  = 2;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_RX_VALID = 4;
    localparam int ST_RX_OVR   = 5;
    localparam int ST_RX_FERR  = 6;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is still accepted
// when a pop frees a slot on the same edge.
module mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART beside data BRAM: TX FIFO + serialiser, STATUS/RX regs.
// Define UART_RX_EN to build the receiver; otherwise uart_rx is ignored.
module mmio_uart
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h10100,
    parameter int          BAUD_DIV   = 868,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  write_enable,
    input  logic        rd_en,
    output logic [31:0] dout,
    output logic        hit,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int             CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic [3:0]  w_off;
    logic        w_tx_push, w_w1c, w_tx_pop, w_tx_drop;
    logic [7:0]  w_fifo_dout;
    logic        w_fifo_full, w_fifo_empty;
    logic [31:0] w_rdata;
    logic        w_rx_valid, w_rx_ovr, w_rx_ferr;
    logic [7:0]  w_rx_byte;
    logic        w_unused;

    tx_state_t     r_tx_state, w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [7:0]    r_tx_shift;
    logic [2:0]    r_tx_bit;
    logic          r_tx, r_tx_ovf;
    logic          w_tx_tick, w_tx_reload, w_line;
    logic [31:0]   r_dout;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = addr[3:0];
    assign w_tx_push = hit && write_enable[0] && (w_off == OFF_TXDATA);
    assign w_w1c     = hit && write_enable[0] && (w_off == OFF_STATUS);
    assign w_tx_drop = w_tx_push && w_fifo_full && !w_tx_pop;
    assign w_unused  = ^{din, write_enable, rd_en, uart_rx};

    mmio_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txq (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_din   (din[7:0]),
        .i_pop   (w_tx_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_tx_tick = (r_tx_cnt == '0);

    always_comb begin
        w_tx_next   = r_tx_state;
        w_tx_pop    = 1'b0;
        w_tx_reload = 1'b0;
        case (r_tx_state)
            TX_IDLE: if (!w_fifo_empty) begin
                w_tx_pop = 1'b1; w_tx_reload = 1'b1; w_tx_next = TX_START;
            end
            TX_START: if (w_tx_tick) begin
                w_tx_reload = 1'b1; w_tx_next = TX_DATA;
            end
            TX_DATA: if (w_tx_tick) begin
                w_tx_reload = 1'b1;
                if (r_tx_bit == LAST_BIT) w_tx_next = TX_STOP;
            end
            TX_STOP: if (w_tx_tick) begin
                if (!w_fifo_empty) begin
                    w_tx_pop = 1'b1; w_tx_reload = 1'b1; w_tx_next = TX_START;
                end else begin
                    w_tx_next = TX_IDLE;
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    // Line level is registered from the next state so uart_tx never glitches.
    always_comb begin
        w_line = 1'b1;
        case (w_tx_next)
            TX_START: w_line = 1'b0;
            TX_DATA:  w_line = (r_tx_state == TX_DATA && w_tx_tick) ? r_tx_shift[1] : r_tx_shift[0];
            default:  w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx       <= 1'b1;
            r_tx_ovf   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_reload)          r_tx_cnt <= BAUD_LAST;
            else if (r_tx_cnt != '0)  r_tx_cnt <= r_tx_cnt - 1'b1;
            if (w_tx_pop) begin
                r_tx_shift <= w_fifo_dout;
                r_tx_bit   <= '0;
            end else if (r_tx_state == TX_DATA && w_tx_tick) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_tx_bit   <= r_tx_bit + 1'b1;
            end
            r_tx <= w_line;
            if (w_tx_drop)                  r_tx_ovf <= 1'b1;
            else if (w_w1c && din[ST_TX_OVF]) r_tx_ovf <= 1'b0;
        end
    end

    assign uart_tx = r_tx;

`ifdef UART_RX_EN
    rx_state_t     r_rx_state, w_rx_next;
    logic [CW-1:0] r_rx_cnt;
    logic [7:0]    r_rx_shift, r_rx_byte;
    logic [2:0]    r_rx_bit;
    logic          r_sync1, r_sync2, r_rx_prev;
    logic          r_rx_valid, r_rx_ovr, r_rx_ferr;
    logic          w_rx_tick, w_rx_half, w_rx_reload, w_rx_done, w_rx_bad, w_rx_pop;

    assign w_rx_tick = (r_rx_cnt == '0);
    assign w_rx_pop  = hit && rd_en && (w_off == OFF_RXDATA);

    always_comb begin
        w_rx_next   = r_rx_state;
        w_rx_half   = 1'b0;
        w_rx_reload = 1'b0;
        w_rx_done   = 1'b0;
        w_rx_bad    = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (r_rx_prev && !r_sync2) begin
                w_rx_half = 1'b1; w_rx_next = RX_START;
            end
            RX_START: if (w_rx_tick) begin
                if (!r_sync2) begin w_rx_reload = 1'b1; w_rx_next = RX_DATA; end
                else          w_rx_next = RX_IDLE;
            end
            RX_DATA: if (w_rx_tick) begin
                w_rx_reload = 1'b1;
                if (r_rx_bit == LAST_BIT) w_rx_next = RX_STOP;
            end
            RX_STOP: if (w_rx_tick) begin
                w_rx_next = RX_IDLE;
                if (r_sync2) w_rx_done = 1'b1;
                else         w_rx_bad  = 1'b1;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            {r_sync1, r_sync2, r_rx_prev} <= 3'b111;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_bit   <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            {r_rx_prev, r_sync2, r_sync1} <= {r_sync2, r_sync1, uart_rx};
            if (w_rx_half)            r_rx_cnt <= CW'(BAUD_DIV / 2 - 1);
            else if (w_rx_reload)     r_rx_cnt <= BAUD_LAST;
            else if (r_rx_cnt != '0)  r_rx_cnt <= r_rx_cnt - 1'b1;
            if (w_rx_half) r_rx_bit <= '0;
            if (r_rx_state == RX_DATA && w_rx_tick) begin
                r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 1'b1;
            end
            // A completing frame beats a same-edge RXDATA pop; that pop is not an overrun.
            if (w_rx_done) begin
                r_rx_byte  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (w_rx_pop) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_done && r_rx_valid && !w_rx_pop) r_rx_ovr <= 1'b1;
            else if (w_w1c && din[ST_RX_OVR])         r_rx_ovr <= 1'b0;
            if (w_rx_bad)                             r_rx_ferr <= 1'b1;
            else if (w_w1c && din[ST_RX_FERR])        r_rx_ferr <= 1'b0;
        end
    end

    assign w_rx_valid = r_rx_valid;
    assign w_rx_ovr   = r_rx_ovr;
    assign w_rx_ferr  = r_rx_ferr;
    assign w_rx_byte  = r_rx_byte;
`else
    assign w_rx_valid = 1'b0;
    assign w_rx_ovr   = 1'b0;
    assign w_rx_ferr  = 1'b0;
    assign w_rx_byte  = 8'h00;
`endif

    always_comb begin
        w_rdata = '0;
        if (hit) begin
            case (w_off)
                OFF_STATUS: w_rdata = {25'd0, w_rx_ferr, w_rx_ovr, w_rx_valid, r_tx_ovf,
                                       (r_tx_state != TX_IDLE), w_fifo_empty, w_fifo_full};
                OFF_RXDATA: w_rdata = {24'd0, w_rx_byte};
                default:    w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_dout <= '0;
        else     r_dout <= w_rdata;
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_mmio_uart.sv
// Randomised bench for mmio_uart against a frame-timer / byte-queue model of the
// TX path and a per-frame model of the receiver (when UART_RX_EN is defined).
module tb_mmio_uart;
    localparam logic [31:0] BASE  = 32'h10100;
    localparam int          BD    = 4;
    localparam int          FD    = 4;
    localparam int          FRAME = 10 * BD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [3:0]  write_enable = '0;
    logic        rd_en = 1'b0;
    logic [31:0] dout;
    logic        hit;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    always #5 clk = ~clk;

    mmio_uart #(.BASE_ADDR(BASE), .BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .write_enable(write_enable),
        .rd_en(rd_en), .dout(dout), .hit(hit), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] m_q[$];
    int         m_rem = 0;
    logic [7:0] m_cur = '0;
    logic       m_ovf = 1'b0, m_rxv = 1'b0, m_rxo = 1'b0, m_rxf = 1'b0;
    logic [7:0] m_rxb = '0;
    logic       rx_lvl = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'd0;
        case (a[3:0])
            4'h4:    return {25'd0, m_rxf, m_rxo, m_rxv, m_ovf, (m_rem > 0),
                             (m_q.size() == 0), (m_q.size() == FD)};
            4'hC:    return {24'd0, m_rxb};
            default: return 32'd0;
        endcase
    endfunction

    // Frame timeline: k-th bit period since the pop; 0 = start, 1..8 = data, 9 = stop.
    function automatic logic m_line();
        int k;
        if (m_rem == 0) return 1'b1;
        k = (FRAME - m_rem) / BD;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    task automatic m_edge(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input logic re);
        logic h, pop, drop;
        h    = (a[31:4] == BASE[31:4]);
        pop  = (m_q.size() > 0) && (m_rem <= 1);
        drop = 1'b0;
        if (m_rem > 0) m_rem--;
        if (pop) begin
            m_cur = m_q.pop_front();
            m_rem = FRAME;
        end
        if (h && a[3:0] == 4'h0 && we[0]) begin
            if (m_q.size() < FD) m_q.push_back(d[7:0]);
            else                 drop = 1'b1;
        end
        if (h && a[3:0] == 4'h4 && we[0]) begin
            if (d[3]) m_ovf = 1'b0;
            if (d[5]) m_rxo = 1'b0;
            if (d[6]) m_rxf = 1'b0;
        end
        if (drop) m_ovf = 1'b1;
        if (h && a[3:0] == 4'hC && re) m_rxv = 1'b0;
    endtask

    task automatic tick(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input logic re);
        logic [31:0] exp_rd;
        addr = a; din = d; write_enable = we; rd_en = re; uart_rx = rx_lvl;
        exp_rd = m_read(a);
        #1 check("hit", {31'd0, hit}, {31'd0, (a[31:4] == BASE[31:4])});
        @(posedge clk);
        m_edge(a, d, we, re);
        @(negedge clk);
        check("dout", dout, exp_rd);
        check("uart_tx", {31'd0, uart_tx}, {31'd0, m_line()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        tick(BASE + {28'd0, off}, d, 4'h1, 1'b0);
    endtask

    task automatic rd(input logic [3:0] off, input logic re);
        tick(BASE + {28'd0, off}, 32'h0, 4'h0, re);
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && (m_rem > 0 || m_q.size() > 0); n++) idle(1);
        idle(2);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_lvl = fr[i];
            idle(BD);
        end
        rx_lvl = 1'b1;
        idle(12);
        if (stop) begin
            if (m_rxv) m_rxo = 1'b1;
            m_rxv = 1'b1;
            m_rxb = b;
        end else begin
            m_rxf = 1'b1;
        end
    endtask

    initial begin
        int r;
        logic [31:0] ra;
        repeat (2) @(negedge clk);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_dout", dout, 32'd0);
        rst = 1'b0;
        rd(4'h4, 1'b0);

        // Single byte 0xA5: frame timing checked cycle by cycle.
        wr(4'h0, 32'hA5);
        idle(45);

        // Burst beyond FIFO capacity, then W1C of tx_ovf.
        for (int i = 1; i <= 6; i++) wr(4'h0, i);
        rd(4'h4, 1'b0);
        wr(4'h4, 32'h8);
        rd(4'h4, 1'b0);
        drain();

        // Four queued bytes must go out back to back.
        for (int i = 0; i < 4; i++) wr(4'h0, 32'h30 + i);
        idle(4 * FRAME + 4);
        rd(4'h4, 1'b0);

        for (int n = 0; n < 900; n++) begin
            r = $urandom_range(0, 99);
            if (r < 30)       wr(4'h0, $urandom);
            else if (r < 38)  wr(4'h4, $urandom);
            else if (r < 55) begin
                ra = $urandom;
                rd(ra[3:0], ra[4]);
            end else if (r < 62) begin
                ra = ($urandom_range(0, 1) == 0) ? $urandom : (BASE + $urandom_range(0, 15));
                tick(ra, $urandom, 4'($urandom), 1'($urandom));
            end else idle(1);
        end
        drain();
        rd(4'h4, 1'b0);

        // Asynchronous reset in the middle of a frame.
        wr(4'h0, 32'h3C);
        idle(10);
        #2 rst = 1'b1;
        #1 check("rst_mid_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_mid_dout", dout, 32'd0);
        m_q.delete(); m_rem = 0; m_ovf = 1'b0;
        m_rxv = 1'b0; m_rxo = 1'b0; m_rxf = 1'b0; m_rxb = '0;
        @(negedge clk);
        rst = 1'b0;
        rd(4'h4, 1'b0);
        idle(3);

`ifdef UART_RX_EN
        send_rx(8'h3C, 1'b1);
        rd(4'h4, 1'b0);
        rd(4'hC, 1'b1);
        rd(4'h4, 1'b0);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd(4'h4, 1'b0);
        rd(4'hC, 1'b1);
        send_rx(8'h77, 1'b0);
        rd(4'h4, 1'b0);
        wr(4'h4, 32'h60);
        rd(4'h4, 1'b0);
        for (int i = 0; i < 3; i++) send_rx(8'($urandom), 1'($urandom_range(0, 3) != 0));
        rd(4'h4, 1'b0);
        rd(4'hC, 1'b1);
`else
        send_rx(8'h3C, 1'b1);
        m_rxv = 1'b0; m_rxo = 1'b0; m_rxb = '0;
        rd(4'h4, 1'b0);
        rd(4'hC, 1'b1);
`endif
        rd(4'h4, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
